complex_adder: RTL and testbench



---
 rtl/complex_adder.sv | 71 +++++++
 tb/tb_complex_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/complex_adder.sv
// Registered complex adder/subtractor: independent real and imaginary lanes,
// each with overflow detection and optional saturation, one-cycle latency.
module complex_adder #(
   parameter int DATA_W   = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2*DATA_W-1:0]   a,
   input  logic [2*DATA_W-1:0]   b,
   input  logic                  in_valid,
   input  logic                  sub,
   output logic [2*DATA_W-1:0]   c,
   output logic                  out_valid,
   output logic                  ovf_real,
   output logic                  ovf_imag
);

   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   // Returns {overflow, result} for one component, computed exactly at DATA_W+1 bits.
   function automatic logic [DATA_W:0] calc_part(
      input logic [DATA_W-1:0] x,
      input logic [DATA_W-1:0] y,
      input logic              do_sub
   );
      logic [DATA_W:0]   ext_x;
      logic [DATA_W:0]   ext_y;
      logic [DATA_W:0]   exact;
      logic              ovf;
      logic [DATA_W-1:0] res;
      ext_x = {x[DATA_W-1], x};
      ext_y = {y[DATA_W-1], y};
      exact = do_sub ? (ext_x - ext_y) : (ext_x + ext_y);
      // The extra bit disagrees with the DATA_W sign bit only when out of range.
      ovf   = exact[DATA_W] ^ exact[DATA_W-1];
      if (ovf && SATURATE)
         res = exact[DATA_W] ? MIN_VAL : MAX_VAL;
      else
         res = exact[DATA_W-1:0];
      return {ovf, res};
   endfunction

   logic [DATA_W:0] part_real;
   logic [DATA_W:0] part_imag;

   // NOTE: combinational outputs are assigned unconditionally, so no latch can be inferred.
   always_comb begin
      part_real = calc_part(a[2*DATA_W-1:DATA_W], b[2*DATA_W-1:DATA_W], sub);
      part_imag = calc_part(a[DATA_W-1:0],        b[DATA_W-1:0],        sub);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c         <= '0;
         out_valid <= 1'b0;
         ovf_real  <= 1'b0;
         ovf_imag  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c        <= {part_real[DATA_W-1:0], part_imag[DATA_W-1:0]};
            ovf_real <= part_real[DATA_W];
            ovf_imag <= part_imag[DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_complex_adder.sv
// Directed self-checking bench for complex_adder; a saturating and a wrapping
// instance share the same stimulus.
module tb_complex_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic        sub;
   logic [31:0] c_sat, c_wrap;
   logic        ov_sat, ov_wrap;
   logic        ovr_sat, ovi_sat, ovr_wrap, ovi_wrap;

   int compared   = 0;
   int mismatched = 0;

   complex_adder #(.DATA_W(16), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .sub(sub),
      .c(c_sat), .out_valid(ov_sat), .ovf_real(ovr_sat), .ovf_imag(ovi_sat)
   );

   complex_adder #(.DATA_W(16), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .sub(sub),
      .c(c_wrap), .out_valid(ov_wrap), .ovf_real(ovr_wrap), .ovf_imag(ovi_wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pack(input int re, input int im);
      logic [31:0] r;
      r = {re[15:0], im[15:0]};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one vector, clock it in, and land 1 time unit after the edge.
   task automatic apply(input int are, input int aim, input int bre, input int bim, input logic s);
      a        = pack(are, aim);
      b        = pack(bre, bim);
      sub      = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_sat(input string tag, input int re, input int im,
                            input logic ovr, input logic ovi);
      check({tag, ".c"},     c_sat,           pack(re, im));
      check({tag, ".valid"}, {31'b0, ov_sat}, 32'd1);
      check({tag, ".ovf"},   {30'b0, ovr_sat, ovi_sat}, {30'b0, ovr, ovi});
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      sub      = 1'b0;
      a        = pack(5, 5);
      b        = pack(5, 5);
      #1;
      check("rst.c",     c_sat, 32'h0);
      check("rst.flags", {29'b0, ov_sat, ovr_sat, ovi_sat}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold.valid", {31'b0, ov_sat}, 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.valid", {31'b0, ov_sat}, 32'd0);

      apply(1023, 1023, 1023, 1023, 1'b0);
      check_sat("add", 2046, 2046, 1'b0, 1'b0);

      apply(1023, -1024, 1023, -1024, 1'b0);
      check_sat("mixed1", 2046, -2048, 1'b0, 1'b0);
      apply(1023, 1023, -1024, -1024, 1'b0);
      check_sat("mixed2", -1, -1, 1'b0, 1'b0);
      apply(1023, 0, -1024, 0, 1'b0);
      check_sat("mixed3", -1, 0, 1'b0, 1'b0);

      apply(0, 1023, 0, 1023, 1'b0);
      check_sat("imag_only", 0, 2046, 1'b0, 1'b0);
      apply(-1024, 0, -1024, 0, 1'b0);
      check_sat("real_only", -2048, 0, 1'b0, 1'b0);

      apply(32767, -32768, 1, -1, 1'b0);
      check_sat("sat", 32767, -32768, 1'b1, 1'b1);
      check("wrap.c",   c_wrap, pack(-32768, 32767));
      check("wrap.ovf", {30'b0, ovr_wrap, ovi_wrap}, 32'd3);

      // Idle cycle with different inputs: outputs and flags must hold.
      in_valid = 1'b0;
      a        = pack(1, 1);
      b        = pack(2, 2);
      @(posedge clk);
      #1;
      check("hold.valid", {31'b0, ov_sat}, 32'd0);
      check("hold.c",     c_sat, pack(32767, -32768));
      check("hold.ovf",   {30'b0, ovr_sat, ovi_sat}, 32'd3);

      apply(100, -5, 30, 7, 1'b1);
      check_sat("sub", 70, -12, 1'b0, 1'b0);
      apply(0, 0, -32768, 0, 1'b1);
      check_sat("sub_min", 32767, 0, 1'b1, 1'b0);
      check("sub_min_wrap.c", c_wrap, pack(-32768, 0));

      apply(1, 2, 3, 4, 1'b0);
      check_sat("stream0", 4, 6, 1'b0, 1'b0);
      apply(10, -10, 5, 5, 1'b0);
      check_sat("stream1", 15, -5, 1'b0, 1'b0);
      apply(-7, 7, 3, 3, 1'b1);
      check_sat("stream2", -10, 4, 1'b0, 1'b0);
      apply(32767, 0, 0, 0, 1'b0);
      check_sat("stream3", 32767, 0, 1'b0, 1'b0);

      // Reset mid-stream with a vector in flight.
      a  = pack(9, 9);
      b  = pack(9, 9);
      #2;
      rst = 1'b1;
      #1;
      check("midrst.c",     c_sat, 32'h0);
      check("midrst.flags", {29'b0, ov_sat, ovr_sat, ovi_sat}, 32'h0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("after_rst.valid", {31'b0, ov_sat}, 32'd0);
      check("after_rst.c",     c_sat, 32'h0);

      apply(-3, 8, 4, -2, 1'b0);
      check_sat("resume", 1, 6, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("resume_end.valid", {31'b0, ov_sat}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
